// File: rtl/seq_det_mealy_param.sv
// Parameterised Mealy serial pattern detector with a loadable pattern,
// overlapping/non-overlapping modes and a saturating match counter.
module seq_det_mealy_param #(
    parameter int NBITS = 3,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       in_,
    input  logic                       overlap,
    input  logic                       cfg_load,
    input  logic [NBITS-1:0]           cfg_pattern,
    input  logic                       clr_cnt,
    output logic                       out,
    output logic [CNT_W-1:0]           match_cnt,
    output logic                       sticky,
    output logic [$clog2(NBITS+1)-1:0] fill
);

    localparam int FW = $clog2(NBITS+1);
    localparam logic [FW-1:0] FULL = FW'(NBITS-1);

    // Alternating ...0101 with a 1 in the LSB, e.g. 101 for three bits.
    function automatic logic [NBITS-1:0] reset_pattern();
        logic [NBITS-1:0] r;
        for (int i = 0; i < NBITS; i++) begin
            r[i] = (i % 2 == 0);
        end
        return r;
    endfunction

    localparam logic [NBITS-1:0] RST_PAT = reset_pattern();

    logic [NBITS-1:0] pat;
    logic [NBITS-2:0] hist;
    logic [NBITS-1:0] win;
    logic             accept;
    logic             full;

    // Candidate window: stored history with the current bit appended.
    assign win    = {hist, in_};
    assign accept = en & ~cfg_load;
    assign full   = (fill == FULL);
    assign out    = ~reset & accept & full & (win == pat);

    // History, fill level, pattern and match bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat       <= RST_PAT;
            hist      <= '0;
            fill      <= '0;
            match_cnt <= '0;
            sticky    <= 1'b0;
        end else begin
            if (cfg_load) begin
                pat  <= cfg_pattern;
                hist <= '0;
                fill <= '0;
            end else if (en) begin
                if (out && !overlap) begin
                    hist <= '0;
                    fill <= '0;
                end else begin
                    hist <= win[NBITS-2:0];
                    if (!full) begin
                        fill <= fill + FW'(1);
                    end
                end
            end

            if (clr_cnt) begin
                match_cnt <= '0;
                sticky    <= 1'b0;
            end else if (out) begin
                sticky <= 1'b1;
                if (match_cnt != {CNT_W{1'b1}}) begin
                    match_cnt <= match_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_det_mealy_param.sv
// Directed bench for seq_det_mealy_param: default instance plus a
// 2-bit-counter instance sharing the same stimulus.
module tb_seq_det_mealy_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       in_;
    logic       overlap;
    logic       cfg_load;
    logic [2:0] cfg_pattern;
    logic       clr_cnt;

    logic       out;
    logic [7:0] cnt;
    logic       sticky;
    logic [1:0] fill;
    logic       out2;
    logic [1:0] cnt2;
    logic       sticky2;
    logic [1:0] fill2;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seq_det_mealy_param #(.NBITS(3), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .en(en), .in_(in_),
        .overlap(overlap), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .clr_cnt(clr_cnt),
        .out(out), .match_cnt(cnt), .sticky(sticky), .fill(fill)
    );

    seq_det_mealy_param #(.NBITS(3), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .en(en), .in_(in_),
        .overlap(overlap), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .clr_cnt(clr_cnt),
        .out(out2), .match_cnt(cnt2), .sticky(sticky2), .fill(fill2)
    );

    // Count one comparison and report it if it mismatches.
    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One cycle of stimulus, starting at a falling edge; out is checked
    // mid-low-phase, then control strobes drop at the next falling edge.
    task automatic cyc(input logic e, input logic b, input logic ld,
                       input logic clr, input logic [2:0] p,
                       input logic exp, input string tag);
        en          = e;
        in_         = b;
        cfg_load    = ld;
        clr_cnt     = clr;
        cfg_pattern = p;
        #1 chk(tag, {31'd0, out}, {31'd0, exp});
        @(negedge clk);
        en       = 1'b0;
        cfg_load = 1'b0;
        clr_cnt  = 1'b0;
    endtask

    task automatic bits(input logic b, input logic exp, input string tag);
        cyc(1'b1, b, 1'b0, 1'b0, 3'b000, exp, tag);
    endtask

    initial begin
        reset       = 1'b1;
        en          = 1'b0;
        in_         = 1'b0;
        overlap     = 1'b1;
        cfg_load    = 1'b0;
        cfg_pattern = 3'b000;
        clr_cnt     = 1'b0;

        @(negedge clk);
        chk("rst_out", {31'd0, out}, 0);
        chk("rst_fill", {30'd0, fill}, 0);
        chk("rst_cnt", {24'd0, cnt}, 0);
        chk("rst_sticky", {31'd0, sticky}, 0);
        reset = 1'b0;

        // overlapping: 1,0,1,0,1 -> 0,0,1,0,1
        overlap = 1'b1;
        bits(1, 0, "ov_b0");
        bits(0, 0, "ov_b1");
        bits(1, 1, "ov_b2");
        bits(0, 0, "ov_b3");
        bits(1, 1, "ov_b4");
        chk("ov_cnt", {24'd0, cnt}, 2);
        chk("ov_cnt2", {30'd0, cnt2}, 2);
        chk("ov_sticky", {31'd0, sticky}, 1);

        cyc(0, 0, 1, 1, 3'b101, 0, "clr_a");
        chk("clr_a_cnt", {24'd0, cnt}, 0);
        chk("clr_a_sticky", {31'd0, sticky}, 0);
        chk("clr_a_fill", {30'd0, fill}, 0);

        // non-overlapping: 1,0,1,0,1,1,0,1 -> 0,0,1,0,0,0,0,1
        overlap = 1'b0;
        bits(1, 0, "no_b0");
        bits(0, 0, "no_b1");
        bits(1, 1, "no_b2");
        bits(0, 0, "no_b3");
        bits(1, 0, "no_b4");
        bits(1, 0, "no_b5");
        bits(0, 0, "no_b6");
        bits(1, 1, "no_b7");
        chk("no_cnt", {24'd0, cnt}, 2);

        cyc(0, 0, 1, 1, 3'b101, 0, "clr_b");

        // en gap ignored: 1,(gap 0),0,1
        overlap = 1'b1;
        bits(1, 0, "gap_b0");
        cyc(0, 0, 0, 0, 3'b000, 0, "gap_idle");
        chk("gap_fill", {30'd0, fill}, 1);
        bits(0, 0, "gap_b1");
        bits(1, 1, "gap_b2");

        // cfg_load flushes history and discards its bit
        bits(1, 0, "ld_b0");
        bits(1, 0, "ld_b1");
        cyc(1, 1, 1, 0, 3'b110, 0, "ld_cyc");
        chk("ld_fill", {30'd0, fill}, 0);
        bits(1, 0, "ld_b2");
        bits(1, 0, "ld_b3");
        bits(0, 1, "ld_b4");
        bits(1, 0, "ld_b5");
        bits(1, 0, "ld_b6");
        cyc(1, 0, 1, 0, 3'b110, 0, "ld_gate");
        chk("ld_gate_fill", {30'd0, fill}, 0);
        chk("ld_cnt", {24'd0, cnt}, 2);

        // saturation of the 2-bit counter
        cyc(0, 0, 1, 1, 3'b101, 0, "clr_c");
        bits(1, 0, "sat_b0");
        bits(0, 0, "sat_b1");
        bits(1, 1, "sat_b2");
        bits(0, 0, "sat_b3");
        bits(1, 1, "sat_b4");
        bits(0, 0, "sat_b5");
        bits(1, 1, "sat_b6");
        bits(0, 0, "sat_b7");
        bits(1, 1, "sat_b8");
        chk("sat_cnt", {24'd0, cnt}, 4);
        chk("sat_cnt2", {30'd0, cnt2}, 3);
        chk("sat_sticky2", {31'd0, sticky2}, 1);

        // clear wins over a simultaneous match
        bits(0, 0, "cw_b0");
        cyc(1, 1, 0, 1, 3'b000, 1, "cw_b1");
        chk("cw_cnt", {24'd0, cnt}, 0);
        chk("cw_cnt2", {30'd0, cnt2}, 0);
        chk("cw_sticky", {31'd0, sticky}, 0);
        chk("cw_sticky2", {31'd0, sticky2}, 0);
        chk("cw_fill", {30'd0, fill}, 2);

        // overlap switched off mid-stream, no flush
        overlap = 1'b0;
        bits(0, 0, "sw_b0");
        bits(1, 1, "sw_b1");
        chk("sw_fill", {30'd0, fill}, 0);
        chk("sw_cnt", {24'd0, cnt}, 1);

        // async reset mid-sequence restores pattern 101
        overlap = 1'b1;
        cyc(0, 0, 1, 0, 3'b011, 0, "pre_rst_ld");
        bits(1, 0, "ar_b0");
        bits(0, 0, "ar_b1");
        en  = 1'b1;
        in_ = 1'b1;
        #1 reset = 1'b1;
        #1;
        chk("ar_out", {31'd0, out}, 0);
        chk("ar_fill", {30'd0, fill}, 0);
        chk("ar_cnt", {24'd0, cnt}, 0);
        chk("ar_sticky", {31'd0, sticky}, 0);
        #1 reset = 1'b0;
        en = 1'b0;
        @(negedge clk);
        bits(1, 0, "ar_b2");
        bits(1, 0, "ar_b3");
        bits(0, 0, "ar_b4");
        bits(1, 1, "ar_b5");
        chk("ar_cnt_end", {24'd0, cnt}, 1);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
